tero_response_collector: RTL and testbench

- Consumer end of the TERO evaluation FSM's response interface.
- Samples the shared oscillation counter on each store_response_puf pulse and divides by the repetition count to get the average.
- Stores one average per TERO loop.
- After the evaluation FSM signals done, compares adjacent loop pairs to form the PUF response word, which it presents on a valid/ready handshake.

---
 rtl/puf_pkg.sv | 20 ++
 rtl/tero_avg_store.sv | 81 ++++++++
 rtl/tero_response_collector.sv | 138 +++++++++++++
 tb/tb_tero_response_collector.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and sizing helpers for the TERO PUF response path.
package puf_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'b00,
    COMPARE = 2'b01,
    OUTPUT  = 2'b10
  } collector_state_t;

  // Loop-index width, identical to the evaluation FSM's select_puf width.
  function automatic int sel_bits_for(input int num_loops);
    return $clog2(num_loops - 1) + 1;
  endfunction

  // Width of a pair counter; never zero so a single pair still has a port.
  function automatic int pair_bits_for(input int num_pairs);
    return (num_pairs > 1) ? $clog2(num_pairs) : 1;
  endfunction

endpackage

// File: rtl/tero_avg_store.sv
// Per-loop average register file with seen[] tracking, write checks and a
// combinational read of one adjacent loop pair.
module tero_avg_store
  import puf_pkg::*;
#(
  parameter int NUM_LOOPS        = 4,
  parameter int CNT_BITS         = 32,
  parameter int REPETITIONS_LOG2 = 12,
  parameter int SEL_BITS         = sel_bits_for(NUM_LOOPS),
  parameter int AVG_BITS         = CNT_BITS - REPETITIONS_LOG2,
  parameter int PAIR_BITS        = pair_bits_for(NUM_LOOPS / 2)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [SEL_BITS-1:0]  wr_sel,
  input  logic [CNT_BITS-1:0]  wr_count,
  input  logic                 clear,
  input  logic [PAIR_BITS-1:0] rd_pair,
  output logic [AVG_BITS-1:0]  rd_even,
  output logic [AVG_BITS-1:0]  rd_odd,
  output logic                 wr_err,
  output logic                 all_seen_next
);

  logic [AVG_BITS-1:0]  avg_q [NUM_LOOPS];
  logic [AVG_BITS-1:0]  avg_d [NUM_LOOPS];
  logic [NUM_LOOPS-1:0] seen_q;
  logic [NUM_LOOPS-1:0] seen_d;
  logic [NUM_LOOPS-1:0] hit;
  logic [AVG_BITS-1:0]  wr_avg;
  logic                 in_range;
  logic                 unused_low_bits;

  // Averaging is a truncating shift; the fractional bits are discarded.
  assign wr_avg          = wr_count[CNT_BITS-1:REPETITIONS_LOG2];
  assign unused_low_bits = ^wr_count[REPETITIONS_LOG2-1:0];

  // One extra bit so NUM_LOOPS itself is representable in the range check.
  assign in_range = ({1'b0, wr_sel} < (SEL_BITS + 1)'(NUM_LOOPS));

  for (genvar gi = 0; gi < NUM_LOOPS; gi++) begin : g_hit
    assign hit[gi] = wr_en && (wr_sel == SEL_BITS'(gi));
  end

  assign wr_err        = wr_en && (!in_range || (|(hit & seen_q)));
  assign all_seen_next = &(seen_q | hit);

  always_comb begin
    for (int i = 0; i < NUM_LOOPS; i++) begin
      avg_d[i] = hit[i] ? wr_avg : avg_q[i];
    end
    seen_d = clear ? '0 : (seen_q | hit);
  end

  always_comb begin
    rd_even = '0;
    rd_odd  = '0;
    for (int i = 0; i < NUM_LOOPS / 2; i++) begin
      if (rd_pair == PAIR_BITS'(i)) begin
        rd_even = avg_q[2*i];
        rd_odd  = avg_q[2*i+1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LOOPS; i++) begin
        avg_q[i] <= '0;
      end
      seen_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LOOPS; i++) begin
        avg_q[i] <= avg_d[i];
      end
      seen_q <= seen_d;
    end
  end

endmodule

// File: rtl/tero_response_collector.sv
// Collects per-loop TERO averages, compares adjacent loop pairs after the
// evaluation FSM finishes and hands the response word out on valid/ready.
module tero_response_collector
  import puf_pkg::*;
#(
  parameter int NUM_LOOPS        = 4,
  parameter int CNT_BITS         = 32,
  parameter int REPETITIONS_LOG2 = 12,
  parameter int SEL_BITS         = sel_bits_for(NUM_LOOPS),
  parameter int AVG_BITS         = CNT_BITS - REPETITIONS_LOG2,
  parameter int RESP_BITS        = NUM_LOOPS / 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 store_response_puf,
  input  logic [SEL_BITS-1:0]  select_puf,
  input  logic [CNT_BITS-1:0]  puf_count,
  input  logic                 fsm_done,
  output logic [RESP_BITS-1:0] response,
  output logic                 response_valid,
  input  logic                 response_ready,
  output logic                 error
);

  localparam int PAIR_BITS = pair_bits_for(RESP_BITS);

  collector_state_t     state_q, state_d;
  logic [PAIR_BITS-1:0] pair_q, pair_d;
  logic [RESP_BITS-1:0] response_q, response_d;
  logic                 valid_q, valid_d;
  logic                 error_q, error_d;
  logic                 err_flag_q, err_flag_d;
  logic                 done_q;
  logic                 done_rise;
  logic                 wr_en;
  logic                 overrun;
  logic                 clear_seen;
  logic                 wr_err;
  logic                 all_seen_next;
  logic [AVG_BITS-1:0]  rd_even;
  logic [AVG_BITS-1:0]  rd_odd;

  assign done_rise = fsm_done & ~done_q;
  assign wr_en     = store_response_puf && (state_q == COLLECT);
  assign overrun   = store_response_puf && (state_q != COLLECT);

  tero_avg_store #(
    .NUM_LOOPS        (NUM_LOOPS),
    .CNT_BITS         (CNT_BITS),
    .REPETITIONS_LOG2 (REPETITIONS_LOG2),
    .SEL_BITS         (SEL_BITS),
    .AVG_BITS         (AVG_BITS),
    .PAIR_BITS        (PAIR_BITS)
  ) u_avg_store (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_sel        (select_puf),
    .wr_count      (puf_count),
    .clear         (clear_seen),
    .rd_pair       (pair_q),
    .rd_even       (rd_even),
    .rd_odd        (rd_odd),
    .wr_err        (wr_err),
    .all_seen_next (all_seen_next)
  );

  always_comb begin
    state_d    = state_q;
    pair_d     = pair_q;
    response_d = response_q;
    valid_d    = valid_q;
    error_d    = error_q;
    err_flag_d = err_flag_q;
    clear_seen = 1'b0;
    case (state_q)
      COLLECT: begin
        if (wr_err) err_flag_d = 1'b1;
        // A store landing with the done edge is already included in all_seen_next.
        if (done_rise) begin
          state_d = COMPARE;
          pair_d  = '0;
          if (!all_seen_next) err_flag_d = 1'b1;
        end
      end
      COMPARE: begin
        for (int i = 0; i < RESP_BITS; i++) begin
          if (pair_q == PAIR_BITS'(i)) response_d[i] = (rd_even > rd_odd);
        end
        if (overrun) err_flag_d = 1'b1;
        // The snapshot uses the registered flag, so a late overrun stays out of it.
        if (pair_q == PAIR_BITS'(RESP_BITS - 1)) begin
          state_d = OUTPUT;
          valid_d = 1'b1;
          error_d = err_flag_q;
        end else begin
          pair_d = pair_q + PAIR_BITS'(1);
        end
      end
      OUTPUT: begin
        if (overrun) err_flag_d = 1'b1;
        if (response_ready) begin
          state_d    = COLLECT;
          valid_d    = 1'b0;
          error_d    = 1'b0;
          err_flag_d = 1'b0;
          clear_seen = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= COLLECT;
      pair_q     <= '0;
      response_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      err_flag_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pair_q     <= pair_d;
      response_q <= response_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      err_flag_q <= err_flag_d;
      done_q     <= fsm_done;
    end
  end

  assign response       = response_q;
  assign response_valid = valid_q;
  assign error          = error_q;

endmodule

// File: tb/tb_tero_response_collector.sv
// Randomised and directed scoreboard bench for tero_response_collector.
module tb_tero_response_collector;

  localparam int N  = 4;
  localparam int CB = 32;
  localparam int RL = 12;
  localparam int SB = 3;
  localparam int RB = N / 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          store_response_puf;
  logic [SB-1:0] select_puf;
  logic [CB-1:0] puf_count;
  logic          fsm_done;
  logic [RB-1:0] response;
  logic          response_valid;
  logic          response_ready;
  logic          error;

  always #5 clk = ~clk;

  tero_response_collector #(
    .NUM_LOOPS        (N),
    .CNT_BITS         (CB),
    .REPETITIONS_LOG2 (RL)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .store_response_puf (store_response_puf),
    .select_puf         (select_puf),
    .puf_count          (puf_count),
    .fsm_done           (fsm_done),
    .response           (response),
    .response_valid     (response_valid),
    .response_ready     (response_ready),
    .error              (error)
  );

  typedef struct packed {
    logic [RB-1:0] resp;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: plain per-loop averages, seen flags and a sticky error.
  int unsigned m_avg [N];
  bit          m_seen[N];
  bit          m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_avg[i]  = 0;
      m_seen[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic do_store(input int sel, input logic [31:0] cnt);
    store_response_puf = 1'b1;
    select_puf         = SB'(sel);
    puf_count          = cnt;
    tick();
    store_response_puf = 1'b0;
    if (sel >= N) begin
      m_err = 1'b1;
    end else begin
      if (m_seen[sel]) m_err = 1'b1;
      m_avg[sel]  = cnt >> RL;
      m_seen[sel] = 1'b1;
    end
  endtask

  task automatic do_sequence(input int hold, input bit pulse);
    exp_t e;
    int   lat;
    for (int k = 0; k < RB; k++) e.resp[k] = (m_avg[2*k] > m_avg[2*k+1]);
    e.err = m_err;
    for (int i = 0; i < N; i++) if (!m_seen[i]) e.err = 1'b1;
    exp_q.push_back(e);
    fsm_done = 1'b1;
    lat = 0;
    while (response_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, RB + 1);
    for (int c = 0; c < hold; c++) begin
      if (pulse && c == 3) begin
        store_response_puf = 1'b1;
        select_puf         = SB'(1);
        puf_count          = 32'hFFFF_FFFF;
      end
      tick();
      store_response_puf = 1'b0;
    end
    response_ready = 1'b1;
    tick();
    response_ready = 1'b0;
    check("valid_after_ack", response_valid, 0);
    check("error_after_ack", error, 0);
    repeat (3) begin
      tick();
      check("no_retrigger", response_valid, 0);
    end
    fsm_done = 1'b0;
    tick();
    for (int i = 0; i < N; i++) m_seen[i] = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic store_all(input logic [31:0] c0, input logic [31:0] c1,
                           input logic [31:0] c2, input logic [31:0] c3);
    do_store(0, c0);
    do_store(1, c1);
    do_store(2, c2);
    do_store(3, c3);
  endtask

  // Monitor: pop on each new response, then hold it to that value while valid.
  initial begin
    exp_t cur;
    bit   have_cur;
    logic prev_valid;
    have_cur   = 1'b0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        have_cur   = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (response_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", response_valid, 0);
            have_cur = 1'b0;
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
            check("response", response, cur.resp);
            check("error", error, cur.err);
          end
        end else if (response_valid && have_cur) begin
          check("stable_response", response, cur.resp);
          check("stable_error", error, cur.err);
        end
        prev_valid = response_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cnt [N];
    int          mode;
    int          start;
    int          dup;

    reset              = 1'b1;
    store_response_puf = 1'b0;
    select_puf         = '0;
    puf_count          = '0;
    fsm_done           = 1'b0;
    response_ready     = 1'b0;
    m_reset();
    #23;
    check("reset_valid", response_valid, 0);
    check("reset_response", response, 0);
    check("reset_error", error, 0);
    reset = 1'b0;
    tick();

    // Nominal: averages 5,4,3,3 -> 2'b01
    store_all(32'h5000, 32'h4000, 32'h3000, 32'h3800);
    do_sequence(0, 1'b0);

    // Truncation gives a tie on pair 0; pair 1 is 2 > 1 -> 2'b10
    store_all(32'h1FFF, 32'h1000, 32'h2000, 32'h1000);
    do_sequence(1, 1'b0);

    // Missing loop 3, then a clean run
    do_store(0, 32'h7000);
    do_store(1, 32'h1000);
    do_store(2, 32'h1000);
    do_sequence(0, 1'b0);
    store_all(32'h1000, 32'h8000, 32'h9000, 32'h2000);
    do_sequence(0, 1'b0);

    // Out-of-range index between valid stores must not alias into loop 1
    do_store(0, 32'h3000);
    do_store(1, 32'h4000);
    do_store(5, 32'hFFFF_F000);
    do_store(2, 32'h2000);
    do_store(3, 32'h1000);
    do_sequence(0, 1'b0);

    // Duplicate on loop 2: last value (avg 1) must win against loop 3 (avg 2)
    store_all(32'h1000, 32'h2000, 32'h9000, 32'h2000);
    do_store(2, 32'h1000);
    do_sequence(0, 1'b0);

    // Backpressure with an overrun store during OUTPUT
    store_all(32'h3000, 32'h1000, 32'h5000, 32'h2000);
    do_sequence(10, 1'b1);

    // Async reset in the middle of COMPARE, after a 2'b11 response
    store_all(32'h3000, 32'h1000, 32'h5000, 32'h2000);
    do_sequence(0, 1'b0);
    store_all(32'h1000, 32'h3000, 32'h1000, 32'h4000);
    fsm_done = 1'b1;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("midreset_valid", response_valid, 0);
    check("midreset_response", response, 0);
    check("midreset_error", error, 0);
    fsm_done = 1'b0;
    m_reset();
    #10;
    reset = 1'b0;
    tick();
    store_all(32'h6000, 32'h2000, 32'h1000, 32'h1000);
    do_sequence(0, 1'b0);

    // Randomised sequences with occasional faults
    for (int it = 0; it < 30; it++) begin
      mode  = $urandom_range(0, 7);
      start = $urandom_range(0, N - 1);
      for (int i = 0; i < N; i++) cnt[i] = $urandom;
      for (int k = 0; k < RB; k++) begin
        if ($urandom_range(0, 3) == 0)
          cnt[2*k+1] = {cnt[2*k][31:RL], 12'($urandom)};
      end
      if (mode == 1) do_store(N + $urandom_range(0, 3), $urandom);
      for (int j = 0; j < N; j++) begin
        if (!(mode == 0 && j == N - 1)) do_store((start + j) % N, cnt[(start + j) % N]);
      end
      if (mode == 2) begin
        dup = $urandom_range(0, N - 1);
        do_store(dup, $urandom);
      end
      do_sequence($urandom_range(0, 4), mode == 3);
    end

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
